mem_port_arbiter: RTL

- Shares one external memory port between two requesters: the instruction-cache refill path (I) and the data-memory path (D).
- Sits between the core's I-cache/data-memory interface and the memory or bus.
- Arbitrates by round-robin, holds exactly one transaction in flight, and returns data or a bus-timeout error to the granted requester.

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one memory port between the I-cache refill path and the data path.
// One transaction is in flight at a time; it ends with read data or a bus-timeout error for the granted side.
module mem_port_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ic_req,
  input  logic [XLEN-1:0] i_ic_addr,
  output logic            o_ic_ready,
  output logic [XLEN-1:0] o_ic_rdata,
  output logic            o_ic_err,
  input  logic            i_dm_req,
  input  logic            i_dm_we,
  input  logic [XLEN-1:0] i_dm_addr,
  input  logic [XLEN-1:0] i_dm_wd,
  input  logic [2:0]      i_dm_f3,
  output logic            o_dm_ready,
  output logic [XLEN-1:0] o_dm_rdata,
  output logic            o_dm_err,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wd,
  output logic [2:0]      o_mem_f3,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  localparam logic        GRANT_D = 1'b1;
  localparam logic [2:0]  F3_WORD = 3'b010;
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wd_q, wd_d;
  logic [2:0]        f3_q, f3_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ic_ready_q, ic_ready_d;
  logic [XLEN-1:0]   ic_rdata_q, ic_rdata_d;
  logic              ic_err_q, ic_err_d;
  logic              dm_ready_q, dm_ready_d;
  logic [XLEN-1:0]   dm_rdata_q, dm_rdata_d;
  logic              dm_err_q, dm_err_d;
  logic              timed_out;
  logic [XLEN-1:0]   resp_data;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wd_d         = wd_q;
    f3_d         = f3_q;
    cnt_d        = cnt_q;
    ic_ready_d   = 1'b0;
    ic_rdata_d   = ic_rdata_q;
    ic_err_d     = ic_err_q;
    dm_ready_d   = 1'b0;
    dm_rdata_d   = dm_rdata_q;
    dm_err_d     = dm_err_q;
    timed_out    = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));
    // Writes return zero; an aborted transfer returns zero too.
    resp_data    = (i_mem_ack && !we_q) ? i_mem_rdata : '0;

    case (state_q)
      IDLE: begin
        if (i_ic_req || i_dm_req) begin
          // On a tie the side that did not win last time gets the port.
          last_grant_d = (i_ic_req && i_dm_req) ? ~last_grant_q : i_dm_req;
          cnt_d        = '0;
          if (last_grant_d == GRANT_D) begin
            state_d = BUSY_D;
            we_d    = i_dm_we;
            addr_d  = i_dm_addr;
            wd_d    = i_dm_wd;
            f3_d    = i_dm_f3;
          end else begin
            state_d = BUSY_I;
            we_d    = 1'b0;
            addr_d  = i_ic_addr;
            wd_d    = '0;
            f3_d    = F3_WORD;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (i_mem_ack || timed_out) begin
          state_d = DONE;
          if (state_q == BUSY_I) begin
            ic_ready_d = 1'b1;
            ic_rdata_d = resp_data;
            ic_err_d   = !i_mem_ack;
          end else begin
            dm_ready_d = 1'b1;
            dm_rdata_d = resp_data;
            dm_err_d   = !i_mem_ack;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wd_q         <= '0;
      f3_q         <= '0;
      cnt_q        <= '0;
      ic_ready_q   <= 1'b0;
      ic_rdata_q   <= '0;
      ic_err_q     <= 1'b0;
      dm_ready_q   <= 1'b0;
      dm_rdata_q   <= '0;
      dm_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wd_q         <= wd_d;
      f3_q         <= f3_d;
      cnt_q        <= cnt_d;
      ic_ready_q   <= ic_ready_d;
      ic_rdata_q   <= ic_rdata_d;
      ic_err_q     <= ic_err_d;
      dm_ready_q   <= dm_ready_d;
      dm_rdata_q   <= dm_rdata_d;
      dm_err_q     <= dm_err_d;
    end
  end

  assign o_mem_req  = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign o_mem_we   = we_q;
  assign o_mem_addr = addr_q;
  assign o_mem_wd   = wd_q;
  assign o_mem_f3   = f3_q;
  assign o_ic_ready = ic_ready_q;
  assign o_ic_rdata = ic_rdata_q;
  assign o_ic_err   = ic_err_q;
  assign o_dm_ready = dm_ready_q;
  assign o_dm_rdata = dm_rdata_q;
  assign o_dm_err   = dm_err_q;

endmodule
